pa_f_spsram_1024x4_ctrl: RTL and testbench

Controller for one 1024x4 single-port SRAM macro (active-low CEN/GWEN/WEN interface, one-cycle read latency).
- After reset, and on request, clears the whole array to INIT_VAL with a hardware sweep.
- Then shares the single port between two requesters using round-robin arbitration with per-bit write masks.
- Sits between the FPU-side requesters and the SRAM macro; it is the only driver of the macro's A/CEN/GWEN/WEN/D pins.

---
 rtl/pa_f_spsram_1024x4_ctrl_if.sv | 48 ++++
 rtl/pa_f_spsram_1024x4_ctrl.sv | 113 +++++++++++
 tb/tb_pa_f_spsram_1024x4_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pa_f_spsram_1024x4_ctrl_if.sv
// Requester and SRAM-macro signal bundle for the 1024x4 single-port SRAM controller.
// The controller uses the slave side; requesters and the macro together form the master side.
interface pa_f_spsram_1024x4_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 4
);
    logic                  init_req;
    logic                  init_done;

    logic                  p0_req;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic [DATA_WIDTH-1:0] p0_wmask;
    logic                  p0_gnt;
    logic                  p0_rvld;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic [DATA_WIDTH-1:0] p1_wmask;
    logic                  p1_gnt;
    logic                  p1_rvld;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;

    modport slave (
        input  init_req, p0_req, p0_we, p0_addr, p0_wdata, p0_wmask,
               p1_req, p1_we, p1_addr, p1_wdata, p1_wmask, Q,
        output init_done, p0_gnt, p0_rvld, p0_rdata, p1_gnt, p1_rvld, p1_rdata,
               A, CEN, GWEN, WEN, D
    );

    modport master (
        output init_req, p0_req, p0_we, p0_addr, p0_wdata, p0_wmask,
               p1_req, p1_we, p1_addr, p1_wdata, p1_wmask, Q,
        input  init_done, p0_gnt, p0_rvld, p0_rdata, p1_gnt, p1_rvld, p1_rdata,
               A, CEN, GWEN, WEN, D
    );
endinterface

// File: rtl/pa_f_spsram_1024x4_ctrl.sv
// Single-port SRAM controller: hardware clear sweep after reset/init_req, then
// round-robin sharing of the port between two requesters with per-bit write masks.
module pa_f_spsram_1024x4_ctrl #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input logic CLK,
    input logic RST,
    pa_f_spsram_1024x4_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] a_last;
    logic [DATA_WIDTH-1:0] d_last;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
    logic                  rr, done, rvld0, rvld1;
    logic                  run, gnt0, gnt1;

    // rr holds the id of the last granted port; the other one wins a tie
    always_comb begin
        run  = (state == RUN);
        gnt0 = run & bus.p0_req & (~bus.p1_req | rr);
        gnt1 = run & bus.p1_req & (~bus.p0_req | ~rr);
    end

    always_comb begin
        bus.A    = a_last;
        bus.D    = d_last;
        bus.CEN  = 1'b1;
        bus.GWEN = 1'b1;
        bus.WEN  = '1;
        if (!run) begin
            bus.A    = cnt;
            bus.D    = INIT_VAL;
            bus.CEN  = 1'b0;
            bus.GWEN = 1'b0;
            bus.WEN  = '0;
        end else if (gnt0) begin
            bus.A    = bus.p0_addr;
            bus.D    = bus.p0_wdata;
            bus.CEN  = 1'b0;
            bus.GWEN = ~bus.p0_we;
            bus.WEN  = bus.p0_we ? ~bus.p0_wmask : '1;
        end else if (gnt1) begin
            bus.A    = bus.p1_addr;
            bus.D    = bus.p1_wdata;
            bus.CEN  = 1'b0;
            bus.GWEN = ~bus.p1_we;
            bus.WEN  = bus.p1_we ? ~bus.p1_wmask : '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= INIT;
            cnt      <= '0;
            rr       <= 1'b1;
            done     <= 1'b0;
            rvld0    <= 1'b0;
            rvld1    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            a_last   <= '0;
            d_last   <= '0;
        end else begin
            a_last <= bus.A;
            d_last <= bus.D;
            rvld0  <= gnt0 & ~bus.p0_we;
            rvld1  <= gnt1 & ~bus.p1_we;
            if (rvld0) rdata0_q <= bus.Q;
            if (rvld1) rdata1_q <= bus.Q;
            if (gnt0)      rr <= 1'b0;
            else if (gnt1) rr <= 1'b1;
            case (state)
                INIT: begin
                    if (bus.init_req) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ADDR) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.init_req) begin
                        state <= INIT;
                        cnt   <= '0;
                        done  <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Q is only valid in the rvld cycle, so rdata passes it through then and holds afterwards
    always_comb begin
        bus.init_done = done;
        bus.p0_gnt    = gnt0;
        bus.p1_gnt    = gnt1;
        bus.p0_rvld   = rvld0;
        bus.p1_rvld   = rvld1;
        bus.p0_rdata  = rvld0 ? bus.Q : rdata0_q;
        bus.p1_rdata  = rvld1 ? bus.Q : rdata1_q;
    end
endmodule

// File: tb/tb_pa_f_spsram_1024x4_ctrl.sv
// Directed bench for the 1024x4 SRAM controller with a behavioural SRAM macro model.
module tb_pa_f_spsram_1024x4_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pa_f_spsram_1024x4_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(4)) bus ();

    pa_f_spsram_1024x4_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(4), .INIT_VAL(4'h0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // SRAM macro: active-low controls, one-cycle read latency
    logic [3:0] mem [1024];
    initial bus.Q = 4'h0;
    always @(posedge CLK) begin
        if (bus.CEN === 1'b0) begin
            if (bus.GWEN === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (bus.WEN[b] === 1'b0) mem[bus.A][b] <= bus.D[b];
            end else begin
                bus.Q <= mem[bus.A];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic req, input logic we, input logic [9:0] addr,
                        input logic [3:0] wd, input logic [3:0] wm);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr;
        bus.p0_wdata = wd; bus.p0_wmask = wm;
    endtask

    task automatic set1(input logic req, input logic we, input logic [9:0] addr,
                        input logic [3:0] wd, input logic [3:0] wm);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr;
        bus.p1_wdata = wd; bus.p1_wmask = wm;
    endtask

    // Starts at a cycle where the sweep counter is 0; both requests held high to prove no grants
    task automatic sweep(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            if (bus.A !== 10'(i) || bus.CEN !== 1'b0 || bus.GWEN !== 1'b0 ||
                bus.WEN !== 4'h0 || bus.D !== 4'h0 || bus.init_done !== 1'b0 ||
                bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin
                if (ok) $display("sweep %s diverged at cycle %0d A=%0h", tag, i, bus.A);
                ok = 1'b0;
            end
            if (i == 1023) begin
                bus.p0_req = 1'b0;
                bus.p1_req = 1'b0;
            end
            @(negedge CLK);
            #1;
        end
        chk({tag, "_sweep"}, 32'(ok), 32'd1);
        chk({tag, "_init_done"}, 32'(bus.init_done), 32'd1);
    endtask

    initial begin
        bus.init_req = 1'b0;
        set0(0, 0, 10'h0, 4'h0, 4'h0);
        set1(0, 0, 10'h0, 4'h0, 4'h0);

        // reset state
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_init_done", 32'(bus.init_done), 0);
        chk("rst_rvld0", 32'(bus.p0_rvld), 0);
        chk("rst_rvld1", 32'(bus.p1_rvld), 0);
        RST = 1'b0;
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        sweep("rst");
        chk("bd_155", 32'(mem[10'h155]), 0);
        chk("bd_3ff", 32'(mem[10'h3FF]), 0);

        // full write then read on p0
        set0(1, 1, 10'h155, 4'hA, 4'hF);
        #1;
        chk("w_gnt0", 32'(bus.p0_gnt), 1);
        chk("w_cen", 32'(bus.CEN), 0);
        chk("w_gwen", 32'(bus.GWEN), 0);
        chk("w_wen", 32'(bus.WEN), 32'h0);
        chk("w_a", 32'(bus.A), 32'h155);
        chk("w_d", 32'(bus.D), 32'hA);
        @(negedge CLK);
        set0(1, 0, 10'h155, 4'h0, 4'h0);
        #1;
        chk("r_gnt0", 32'(bus.p0_gnt), 1);
        chk("r_gwen", 32'(bus.GWEN), 1);
        chk("r_wen", 32'(bus.WEN), 32'hF);
        @(negedge CLK);
        set0(0, 0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("r_rvld0", 32'(bus.p0_rvld), 1);
        chk("r_rdata0", 32'(bus.p0_rdata), 32'hA);
        chk("idle_cen", 32'(bus.CEN), 1);
        chk("idle_a_hold", 32'(bus.A), 32'h155);
        @(negedge CLK);
        #1;
        chk("r_rvld0_drop", 32'(bus.p0_rvld), 0);
        chk("r_rdata0_hold", 32'(bus.p0_rdata), 32'hA);

        // masked write 5/0011 over A -> 9
        @(negedge CLK);
        set0(1, 1, 10'h155, 4'h5, 4'b0011);
        #1;
        chk("mw_wen", 32'(bus.WEN), 32'hC);
        @(negedge CLK);
        set0(1, 0, 10'h155, 4'h0, 4'h0);
        @(negedge CLK);
        set0(0, 0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("mw_rvld0", 32'(bus.p0_rvld), 1);
        chk("mw_rdata0", 32'(bus.p0_rdata), 32'h9);

        // zero-mask write on p1 is granted but changes nothing
        @(negedge CLK);
        set1(1, 1, 10'h155, 4'hF, 4'h0);
        #1;
        chk("zm_gnt1", 32'(bus.p1_gnt), 1);
        chk("zm_cen", 32'(bus.CEN), 0);
        chk("zm_wen", 32'(bus.WEN), 32'hF);
        @(negedge CLK);
        set1(1, 0, 10'h155, 4'h0, 4'h0);
        @(negedge CLK);
        set1(1, 1, 10'h3FF, 4'h7, 4'hF);
        #1;
        chk("zm_rvld1", 32'(bus.p1_rvld), 1);
        chk("zm_rdata1", 32'(bus.p1_rdata), 32'h9);
        @(negedge CLK);

        // contention: p0 first, then alternate
        set0(1, 0, 10'h155, 4'h0, 4'h0);
        set1(1, 0, 10'h3FF, 4'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_gnt0_%0d", k), 32'(bus.p0_gnt), 32'((k % 2) == 0));
            chk($sformatf("rr_gnt1_%0d", k), 32'(bus.p1_gnt), 32'((k % 2) == 1));
            if (k > 0) begin
                chk($sformatf("rr_rvld0_%0d", k), 32'(bus.p0_rvld), 32'((k % 2) == 1));
                chk($sformatf("rr_rvld1_%0d", k), 32'(bus.p1_rvld), 32'((k % 2) == 0));
                if (k % 2 == 1) chk($sformatf("rr_rdata0_%0d", k), 32'(bus.p0_rdata), 32'h9);
                else            chk($sformatf("rr_rdata1_%0d", k), 32'(bus.p1_rdata), 32'h7);
            end
            @(negedge CLK);
        end
        set0(0, 0, 10'h0, 4'h0, 4'h0);
        set1(0, 0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("rr_rvld1_last", 32'(bus.p1_rvld), 1);
        chk("rr_rdata1_last", 32'(bus.p1_rdata), 32'h7);
        @(negedge CLK);

        // init_req alongside a p1 read
        set1(1, 0, 10'h3FF, 4'h0, 4'h0);
        bus.init_req = 1'b1;
        #1;
        chk("ir_gnt1", 32'(bus.p1_gnt), 1);
        @(negedge CLK);
        bus.init_req = 1'b0;
        set1(0, 0, 10'h0, 4'h0, 4'h0);
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        #1;
        chk("ir_rvld1", 32'(bus.p1_rvld), 1);
        chk("ir_rdata1", 32'(bus.p1_rdata), 32'h7);
        chk("ir_done_drop", 32'(bus.init_done), 0);
        sweep("ireq");
        chk("ir_bd_3ff", 32'(mem[10'h3FF]), 0);
        set1(1, 0, 10'h3FF, 4'h0, 4'h0);
        @(negedge CLK);
        set1(0, 0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("ir_rd_rvld1", 32'(bus.p1_rvld), 1);
        chk("ir_rd_rdata1", 32'(bus.p1_rdata), 32'h0);
        @(negedge CLK);

        // reset during a read grant drops the pending rvld
        set0(1, 0, 10'h155, 4'h0, 4'h0);
        RST = 1'b1;
        #1;
        chk("rt_gnt0", 32'(bus.p0_gnt), 1);
        @(negedge CLK);
        RST = 1'b0;
        set0(0, 0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("rt_rvld0", 32'(bus.p0_rvld), 0);
        chk("rt_done", 32'(bus.init_done), 0);
        chk("rt_a0", 32'(bus.A), 0);

        // reset at sweep address 500
        repeat (500) @(negedge CLK);
        #1;
        chk("ms_a500", 32'(bus.A), 32'd500);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        #1;
        sweep("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
